// File: rtl/rlbp_cap_pkg.sv
// ============================================================================
// Module  : rlbp_cap_pkg
// Brief   : Shared constants and types for the RLBP serial capture block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rlbp_cap_pkg;

   localparam logic [3:0] c_off_data     = 4'h0;
   localparam logic [3:0] c_off_status   = 4'h4;
   localparam logic [3:0] c_off_ctrl     = 4'h8;
   localparam logic [3:0] c_off_framecnt = 4'hC;

   localparam int c_st_empty   = 8;
   localparam int c_st_full    = 9;
   localparam int c_st_fdone   = 10;
   localparam int c_st_ovf     = 11;
   localparam int c_st_unf     = 12;
   localparam int c_st_restart = 13;

   localparam int c_ctrl_en       = 0;
   localparam int c_ctrl_ie_done  = 1;
   localparam int c_ctrl_ie_level = 2;
   localparam int c_ctrl_clear    = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FLUSH   = 2'd2
   } cap_state_e;

endpackage

`default_nettype wire

// File: rtl/rlbp_cap_fifo.sv
// ============================================================================
// Module  : rlbp_cap_fifo
// Brief   : Synchronous word FIFO; pointers carry an extra wrap bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rlbp_cap_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_clr,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_empty,
   output logic                       o_full
);

   localparam int c_aw = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw:0]    r_wptr;
   logic [c_aw:0]    r_rptr;
   logic             w_do_push;
   logic             w_do_pop;

   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_clr) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_clr) r_mem[r_wptr[c_aw-1:0]] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rptr[c_aw-1:0]];
   assign o_level = r_wptr - r_rptr;
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                    (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);

endmodule

`default_nettype wire

// File: rtl/rlbp_serial_capture.sv
// ============================================================================
// Module  : rlbp_serial_capture
// Brief   : Captures the RLBP macro serial stream into 32-bit words, buffers
//           them and exposes them over a Wishbone slave with an interrupt.
//           Optional frame counter at 0xC: define RLBP_CAP_FRAMECNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rlbp_serial_capture
   import rlbp_cap_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
   parameter int          PIX_BITS   = 8,
   parameter int          FIFO_DEPTH = 8,
   parameter int          IRQ_LEVEL  = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        ser_clk_i,
   input  logic        ser_data_i,
   input  logic        ser_start_i,
   input  logic        ser_done_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        irq_o
);

   localparam int c_aw = $clog2(FIFO_DEPTH);

   if ((32 % PIX_BITS) != 0 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("rlbp_serial_capture: PIX_BITS must divide 32, FIFO_DEPTH must be a power of two >= 2");
   end

   logic [1:0]  r_clk_sync, r_dat_sync, r_start_sync, r_done_sync;
   logic        r_clk_d, r_start_d, r_done_d;
   logic        w_bit_edge, w_start_edge, w_done_edge;

   cap_state_e  r_state, w_state_nxt;
   logic [31:0] r_shift;
   logic [4:0]  r_bitcnt;
   logic [31:0] w_shift_nxt;
   logic        w_frame_init, w_shift_en, w_cap_push, w_set_fdone, w_set_restart;
   logic [31:0] w_cap_data;

   logic        r_en, r_ie_done, r_ie_level, r_clear;
   logic        r_fdone, r_ovf, r_unf, r_restart;
   logic        r_ack, r_irq;
   logic [31:0] r_dat;

   logic [31:0] w_fifo_rdata;
   logic [c_aw:0] w_level;
   logic [7:0]  w_level8;
   logic        w_empty, w_full, w_fifo_pop, w_irq_level;
   logic        w_hit, w_rd, w_wr, w_pop_req, w_set_unf, w_set_ovf, w_w1c;
   logic [3:0]  w_off;
   logic [31:0] w_rdata, w_status, w_framecnt_rd;
   logic        w_unused;

   assign w_unused = ^wbs_sel_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_clk_sync   <= '0;
         r_dat_sync   <= '0;
         r_start_sync <= '0;
         r_done_sync  <= '0;
         r_clk_d      <= 1'b0;
         r_start_d    <= 1'b0;
         r_done_d     <= 1'b0;
      end else begin
         r_clk_sync   <= {r_clk_sync[0],   ser_clk_i};
         r_dat_sync   <= {r_dat_sync[0],   ser_data_i};
         r_start_sync <= {r_start_sync[0], ser_start_i};
         r_done_sync  <= {r_done_sync[0],  ser_done_i};
         r_clk_d      <= r_clk_sync[1];
         r_start_d    <= r_start_sync[1];
         r_done_d     <= r_done_sync[1];
      end
   end

   assign w_bit_edge   = r_clk_sync[1]   & ~r_clk_d;
   assign w_start_edge = r_start_sync[1] & ~r_start_d;
   assign w_done_edge  = r_done_sync[1]  & ~r_done_d;
   assign w_shift_nxt  = {r_shift[30:0], r_dat_sync[1]};

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)   r_state <= ST_IDLE;
      else if (r_clear) r_state <= ST_IDLE;
      else              r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_start_edge && r_en) w_state_nxt = ST_CAPTURE;
         ST_CAPTURE: if (!(w_start_edge && r_en) && w_done_edge) w_state_nxt = ST_FLUSH;
         ST_FLUSH:   w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_frame_init  = 1'b0;
      w_shift_en    = 1'b0;
      w_cap_push    = 1'b0;
      w_cap_data    = w_shift_nxt;
      w_set_fdone   = 1'b0;
      w_set_restart = 1'b0;
      case (r_state)
         ST_IDLE: w_frame_init = w_start_edge & r_en;
         ST_CAPTURE: begin
            if (w_start_edge && r_en) begin
               w_frame_init  = 1'b1;
               w_set_restart = 1'b1;
            end else if (w_bit_edge) begin
               w_shift_en = 1'b1;
               w_cap_push = (r_bitcnt == 5'd31);
            end
         end
         ST_FLUSH: begin
            // Low bitcnt bits hold the partial word; move them to the MSBs.
            w_set_fdone = 1'b1;
            w_cap_push  = (r_bitcnt != 5'd0);
            w_cap_data  = r_shift << (6'd32 - {1'b0, r_bitcnt});
         end
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_shift  <= '0;
         r_bitcnt <= '0;
      end else if (r_clear || w_frame_init) begin
         r_shift  <= '0;
         r_bitcnt <= '0;
      end else if (w_shift_en) begin
         r_shift  <= w_shift_nxt;
         r_bitcnt <= r_bitcnt + 5'd1;
      end
   end

   rlbp_cap_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .i_clr   (r_clear),
      .i_push  (w_cap_push),
      .i_wdata (w_cap_data),
      .i_pop   (w_fifo_pop),
      .o_rdata (w_fifo_rdata),
      .o_level (w_level),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign w_off      = wbs_adr_i[3:0];
   assign w_hit      = wbs_cyc_i & wbs_stb_i & ~r_ack & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign w_rd       = w_hit & ~wbs_we_i;
   assign w_wr       = w_hit &  wbs_we_i;
   assign w_pop_req  = w_rd & (w_off == c_off_data);
   assign w_fifo_pop = w_pop_req & ~w_empty;
   assign w_set_unf  = w_pop_req & w_empty;
   assign w_set_ovf  = w_cap_push & w_full & ~w_fifo_pop;
   assign w_w1c      = w_wr & (w_off == c_off_status);
   assign w_level8   = 8'(w_level);
   assign w_irq_level = ({24'd0, w_level8} >= 32'(IRQ_LEVEL));

   assign w_status = {16'd0, r_state, r_restart, r_unf, r_ovf, r_fdone, w_full, w_empty, w_level8};

`ifdef RLBP_CAP_FRAMECNT_EN
   logic [15:0] r_framecnt;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)
         r_framecnt <= '0;
      else if (r_clear || (w_wr && (w_off == c_off_framecnt)))
         r_framecnt <= '0;
      else if (r_state == ST_FLUSH)
         r_framecnt <= r_framecnt + 16'd1;
   end

   assign w_framecnt_rd = {16'd0, r_framecnt};
`else
   assign w_framecnt_rd = 32'd0;
`endif

   always_comb begin
      w_rdata = '0;
      case (w_off)
         c_off_data:     w_rdata = w_empty ? 32'd0 : w_fifo_rdata;
         c_off_status:   w_rdata = w_status;
         c_off_ctrl:     w_rdata = {29'd0, r_ie_level, r_ie_done, r_en};
         c_off_framecnt: w_rdata = w_framecnt_rd;
         default:        w_rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_ack      <= 1'b0;
         r_dat      <= '0;
         r_en       <= 1'b0;
         r_ie_done  <= 1'b0;
         r_ie_level <= 1'b0;
         r_clear    <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         r_ack   <= w_hit;
         r_dat   <= w_rd ? w_rdata : 32'd0;
         r_clear <= 1'b0;
         if (w_wr && (w_off == c_off_ctrl)) begin
            r_en       <= wbs_dat_i[c_ctrl_en];
            r_ie_done  <= wbs_dat_i[c_ctrl_ie_done];
            r_ie_level <= wbs_dat_i[c_ctrl_ie_level];
            r_clear    <= wbs_dat_i[c_ctrl_clear];
         end
         r_irq <= (r_fdone & r_ie_done) | (w_irq_level & r_ie_level);
      end
   end

   // Sticky flags: a new event wins over a same-cycle W1C.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni || r_clear) begin
         r_fdone   <= 1'b0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
         r_restart <= 1'b0;
      end else begin
         r_fdone   <= w_set_fdone   | (r_fdone   & ~(w_w1c & wbs_dat_i[c_st_fdone]));
         r_ovf     <= w_set_ovf     | (r_ovf     & ~(w_w1c & wbs_dat_i[c_st_ovf]));
         r_unf     <= w_set_unf     | (r_unf     & ~(w_w1c & wbs_dat_i[c_st_unf]));
         r_restart <= w_set_restart | (r_restart & ~(w_w1c & wbs_dat_i[c_st_restart]));
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign irq_o     = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_rlbp_serial_capture.sv
// ============================================================================
// Module  : tb_rlbp_serial_capture
// Brief   : Scoreboard bench for rlbp_serial_capture with a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rlbp_serial_capture;

   localparam logic [31:0] c_base  = 32'h3000_0100;
   localparam int          c_depth = 8;

   logic        wb_clk_i    = 1'b0;
   logic        wb_rst_ni   = 1'b0;
   logic        ser_clk_i   = 1'b0;
   logic        ser_data_i  = 1'b0;
   logic        ser_start_i = 1'b0;
   logic        ser_done_i  = 1'b0;
   logic        wbs_cyc_i   = 1'b0;
   logic        wbs_stb_i   = 1'b0;
   logic        wbs_we_i    = 1'b0;
   logic [3:0]  wbs_sel_i   = 4'hF;
   logic [31:0] wbs_adr_i   = '0;
   logic [31:0] wbs_dat_i   = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        irq_o;

   rlbp_serial_capture #(
      .BASE_ADDR  (c_base),
      .PIX_BITS   (8),
      .FIFO_DEPTH (c_depth),
      .IRQ_LEVEL  (4)
   ) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_ni   (wb_rst_ni),
      .ser_clk_i   (ser_clk_i),
      .ser_data_i  (ser_data_i),
      .ser_start_i (ser_start_i),
      .ser_done_i  (ser_done_i),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_sel_i   (wbs_sel_i),
      .wbs_adr_i   (wbs_adr_i),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_ack_o   (wbs_ack_o),
      .wbs_dat_o   (wbs_dat_o),
      .irq_o       (irq_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   bit          rd_q[$];
   bit          tx_bits[$];
   logic [31:0] mq[$];
   bit          m_en, m_fdone, m_ovf, m_unf, m_restart, m_capturing;
   int          m_frames;
   bit          prev_ack;
   logic [31:0] mon_exp;
   string       mon_name;
   bit          mon_rd;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: every ack pops one scoreboard entry; reads compare data.
   always @(negedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         prev_ack = 1'b0;
      end else begin
         if (wbs_ack_o === 1'b1) begin
            check("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ack: got ack, expected no pending request");
            end else begin
               mon_exp  = exp_q.pop_front();
               mon_name = name_q.pop_front();
               mon_rd   = rd_q.pop_front();
               if (mon_rd) check(mon_name, wbs_dat_o, mon_exp);
            end
         end
         prev_ack = (wbs_ack_o === 1'b1);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge wb_clk_i);
      #1;
   endtask

   task automatic wb_xfer(input bit we, input logic [3:0] off, input logic [31:0] wdat,
                          input logic [31:0] exp, input string nm);
      int lat;
      lat = 0;
      tick(1);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      rd_q.push_back(!we);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = c_base | {28'd0, off};
      wbs_dat_i = wdat;
      do begin
         tick(1);
         lat++;
      end while (wbs_ack_o !== 1'b1 && lat < 20);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      check({nm, "_ack_latency"}, 32'(lat), 32'd1);
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s        = '0;
      s[7:0]   = 8'(mq.size());
      s[8]     = (mq.size() == 0);
      s[9]     = (mq.size() == c_depth);
      s[10]    = m_fdone;
      s[11]    = m_ovf;
      s[12]    = m_unf;
      s[13]    = m_restart;
      return s;
   endfunction

   task automatic rd_status(input string nm);
      wb_xfer(1'b0, 4'h4, 32'd0, m_status(), nm);
   endtask

   task automatic rd_data(input string nm);
      logic [31:0] e;
      if (mq.size() > 0) e = mq.pop_front();
      else begin
         e     = '0;
         m_unf = 1'b1;
      end
      wb_xfer(1'b0, 4'h0, 32'd0, e, nm);
   endtask

   task automatic wr_ctrl(input logic [31:0] v);
      m_en = v[0];
      if (v[3]) begin
         mq.delete();
         {m_fdone, m_ovf, m_unf, m_restart} = '0;
         m_frames    = 0;
         m_capturing = 1'b0;
      end
      wb_xfer(1'b1, 4'h8, v, 32'd0, "wr_ctrl");
   endtask

   task automatic wr_status(input logic [31:0] v);
      if (v[10]) m_fdone   = 1'b0;
      if (v[11]) m_ovf     = 1'b0;
      if (v[12]) m_unf     = 1'b0;
      if (v[13]) m_restart = 1'b0;
      wb_xfer(1'b1, 4'h4, v, 32'd0, "wr_status");
   endtask

   task automatic add_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) tx_bits.push_back(v[i]);
   endtask

   // Frame contents become MSB-first words; the tail word is left-aligned.
   task automatic model_frame();
      int n, nw;
      logic [31:0] w;
      n  = tx_bits.size();
      nw = (n + 31) / 32;
      for (int j = 0; j < nw; j++) begin
         w = '0;
         for (int b = 0; b < 32; b++)
            if (j * 32 + b < n) w[31 - b] = tx_bits[j * 32 + b];
         if (mq.size() < c_depth) mq.push_back(w);
         else m_ovf = 1'b1;
      end
      m_fdone = 1'b1;
      m_frames++;
   endtask

   task automatic ser_bit(input bit b);
      ser_data_i = b;
      tick(3);
      ser_clk_i = 1'b1;
      tick(3);
      ser_clk_i = 1'b0;
   endtask

   task automatic pulse_start();
      if (m_en) begin
         if (m_capturing) m_restart = 1'b1;
         m_capturing = 1'b1;
      end
      ser_start_i = 1'b1;
      tick(4);
      ser_start_i = 1'b0;
      tick(4);
   endtask

   task automatic pulse_done();
      ser_done_i = 1'b1;
      tick(4);
      ser_done_i = 1'b0;
      tick(8);
      if (m_capturing) begin
         model_frame();
         m_capturing = 1'b0;
      end
   endtask

   task automatic send_frame();
      pulse_start();
      foreach (tx_bits[i]) ser_bit(tx_bits[i]);
      pulse_done();
   endtask

   task automatic drain(input string nm);
      while (mq.size() > 0) rd_data(nm);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] fc_exp;
      {m_en, m_fdone, m_ovf, m_unf, m_restart, m_capturing} = '0;
      m_frames = 0;

      // Reset values
      tick(5);
      check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("rst_dat", wbs_dat_o, 32'd0);
      check("rst_irq", {31'd0, irq_o}, 32'd0);
      wb_rst_ni = 1'b1;
      tick(3);
      wb_xfer(1'b0, 4'h4, 32'd0, 32'h0000_0100, "status_after_reset");

      // Full 32-bit word
      wr_ctrl(32'h1);
      tx_bits.delete();
      add_bits(32'hA5C3_0F81, 32);
      send_frame();
      rd_status("status_one_word");
      rd_data("data_full_word");
      rd_status("status_drained");

      // Partial word is left-aligned and zero padded
      tx_bits.delete();
      add_bits(32'h0000_0ABC, 12);
      send_frame();
      wb_xfer(1'b0, 4'h0, 32'd0, 32'hABC0_0000, "data_partial_const");
      void'(mq.pop_front());

      // Overflow: nine words into an eight-deep FIFO
      tx_bits.delete();
      for (int i = 0; i < 9; i++) add_bits($urandom, 32);
      send_frame();
      rd_status("status_overflow");
      for (int i = 0; i < 8; i++) rd_data("data_overflow_order");

      // Underflow and W1C
      rd_data("data_underflow");
      rd_status("status_underflow");
      wr_status(32'h0000_1C00);
      rd_status("status_after_w1c");

      // Restart mid-frame discards the partial word
      pulse_start();
      for (int i = 0; i < 10; i++) ser_bit(1'b1);
      tx_bits.delete();
      add_bits($urandom, 32);
      add_bits($urandom, 5);
      send_frame();
      rd_status("status_restart");
      drain("data_after_restart");
      wr_status(32'h0000_3C00);

      // Random frame lengths
      for (int f = 0; f < 4; f++) begin
         tx_bits.delete();
         for (int i = 0; i < $urandom_range(1, 80); i++) tx_bits.push_back(1'($urandom));
         send_frame();
         rd_status("status_random");
         drain("data_random");
      end

      // Level interrupt at threshold 4
      wr_ctrl(32'h5);
      for (int f = 0; f < 3; f++) begin
         tx_bits.delete();
         add_bits($urandom, 32);
         send_frame();
      end
      @(negedge wb_clk_i);
      check("irq_below_level", {31'd0, irq_o}, 32'd0);
      tx_bits.delete();
      add_bits($urandom, 32);
      send_frame();
      @(negedge wb_clk_i);
      check("irq_at_level", {31'd0, irq_o}, 32'd1);
      rd_data("data_irq");
      tick(2);
      @(negedge wb_clk_i);
      check("irq_after_pop", {31'd0, irq_o}, 32'd0);

      // Frame-done interrupt and its W1C
      wr_ctrl(32'h3);
      tick(2);
      @(negedge wb_clk_i);
      check("irq_done", {31'd0, irq_o}, 32'd1);
      wr_status(32'h0000_0400);
      tick(2);
      @(negedge wb_clk_i);
      check("irq_done_cleared", {31'd0, irq_o}, 32'd0);

      // Control clear empties FIFO and self-clears
      wr_ctrl(32'h9);
      rd_status("status_after_clear");
      wb_xfer(1'b0, 4'h8, 32'd0, 32'h0000_0001, "ctrl_readback");

      // Frame counter (0 when the feature is absent)
      tx_bits.delete();
      add_bits($urandom, 20);
      send_frame();
`ifdef RLBP_CAP_FRAMECNT_EN
      fc_exp = 32'(m_frames);
`else
      fc_exp = 32'd0;
`endif
      wb_xfer(1'b0, 4'hC, 32'd0, fc_exp, "framecnt");
      drain("data_framecnt");

      // Unmapped offsets ack; reads are zero, writes are ignored
      wb_xfer(1'b1, 4'h1, 32'hFFFF_FFFF, 32'd0, "wr_unmapped");
      wb_xfer(1'b0, 4'h2, 32'd0, 32'd0, "rd_unmapped");
      rd_status("status_after_unmapped");

      // Reset asserted mid-frame
      pulse_start();
      for (int i = 0; i < 5; i++) ser_bit(1'($urandom));
      wb_rst_ni = 1'b0;
      tick(2);
      @(negedge wb_clk_i);
      check("midrst_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("midrst_dat", wbs_dat_o, 32'd0);
      check("midrst_irq", {31'd0, irq_o}, 32'd0);
      mq.delete();
      {m_en, m_fdone, m_ovf, m_unf, m_restart, m_capturing} = '0;
      m_frames = 0;
      tick(1);
      wb_rst_ni = 1'b1;
      tick(3);
      wb_xfer(1'b0, 4'h4, 32'd0, 32'h0000_0100, "status_after_midrst");
      wb_xfer(1'b0, 4'h8, 32'd0, 32'd0, "ctrl_after_midrst");

      tick(5);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pending_requests: got %0d, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
